// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth-table sweep checker.
// Stop-on-first-failure behaviour is selected with TT_STOP_ON_FAIL_EN.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Expected truth tables for 2-input gates, bit i = output for input i
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;

    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 255;
    localparam int unsigned CTR_W      = 8;

endpackage

// File: rtl/tt_settle_ctr.sv
// Settle-interval counter: counts held cycles of a vector, flags SETTLE-1.
module tt_settle_ctr
    import tt_check_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CTR_W'(1);
        end
    end

    assign tc_c = (count == CTR_W'(SETTLE - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: sweeps every input vector into a gate and
// compares its output against EXPECT. Optional macro: TT_STOP_ON_FAIL_EN.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int unsigned             N_IN   = 2,
    parameter int unsigned             SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = TT_NOR2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [N_IN-1:0]         dut_in,
    input  logic                    dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic [(1<<N_IN)-1:0]    fail_mask
);

    localparam int unsigned NVEC  = 1 << N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NVEC);

    generate
        if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
            $error("tt_sweep_checker: SETTLE out of range 1..255");
        end
    endgenerate

    state_t           state;
    logic             ctr_clear;
    logic             ctr_enable;
    logic             settle_tc_c;
    logic             mismatch;
    logic             last_vec;
    logic [ERR_W-1:0] err_next;

    assign mismatch   = (dut_out != EXPECT[dut_in]);
    assign last_vec   = (dut_in == N_IN'(NVEC - 1));
    assign err_next   = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1)
                                                             : err_count;
    // Counter sits at zero outside APPLY, so every APPLY entry starts a fresh interval
    assign ctr_clear  = (state != APPLY);
    assign ctr_enable = (state == APPLY) && !settle_tc_c;

    tt_settle_ctr #(
        .SETTLE (SETTLE)
    ) u_settle_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .tc_c   (settle_tc_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        state     <= APPLY;
                        dut_in    <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_mask <= '0;
                    end
                end
                APPLY: begin
                    if (settle_tc_c) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count       <= err_next;
                        fail_mask[dut_in] <= 1'b1;
                    end
`ifdef TT_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (last_vec) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state  <= APPLY;
                        dut_in <= dut_in + N_IN'(1);
                    end
`else
                    // The final vector's result is folded into pass via err_next
                    if (last_vec) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state  <= APPLY;
                        dut_in <= dut_in + N_IN'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
